// File: rtl/sec09_queues_pkg.sv
// Shared types and sizing for the 32-to-8 bit stream serializer.
package sec09_queues_pkg;

    localparam int IN_W           = 32;
    localparam int OUT_W          = 8;
    localparam int BYTES_PER_WORD = IN_W / OUT_W;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/sec09_queues_byte_counter.sv
// Byte index within the held word: async clear, sync load-zero, increment enable.
module sec09_queues_byte_counter
    import sec09_queues_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_zero,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    // load_zero wins so a new word always starts at byte 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (load_zero) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/sec09_queues_stream_serializer.sv
// Splits 32-bit words into four 8-bit beats with valid/ready on both sides;
// a new word may be taken on the final byte so words stream without bubbles.
module sec09_queues_stream_serializer
    import sec09_queues_pkg::*;
#(
    parameter bit p_msb_first = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [IN_W-1:0]  istream_msg,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [OUT_W-1:0] ostream_msg,
    output logic             ostream_last
);

    state_t            state_reg, state_next;
    logic [IN_W-1:0]   word_reg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  sel;
    logic              word_xfer;
    logic              byte_xfer;
    logic [OUT_W-1:0]  lanes [BYTES_PER_WORD];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lanes[gi] = word_reg[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign word_xfer = istream_val && istream_rdy;
    assign byte_xfer = ostream_val && ostream_rdy;
    // ~cnt is 3-cnt for a 2-bit index
    assign sel       = p_msb_first ? ~cnt : cnt;

    always_comb begin
        state_next   = state_reg;
        istream_rdy  = 1'b0;
        ostream_val  = 1'b0;
        ostream_last = 1'b0;
        ostream_msg  = '0;
        case (state_reg)
            IDLE: begin
                istream_rdy = 1'b1;
                if (word_xfer) state_next = SEND;
            end
            SEND: begin
                ostream_val  = 1'b1;
                ostream_msg  = lanes[sel];
                ostream_last = (cnt == LAST_IDX);
                // Only the final byte frees the register, and only if it leaves now
                istream_rdy  = (cnt == LAST_IDX) && ostream_rdy;
                if (byte_xfer && (cnt == LAST_IDX) && !word_xfer) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (word_xfer) word_reg <= istream_msg;
        end
    end

    sec09_queues_byte_counter u_byte_counter (
        .clk       (clk),
        .reset     (reset),
        .load_zero (word_xfer || (byte_xfer && ostream_last)),
        .inc       (byte_xfer && !ostream_last),
        .cnt       (cnt)
    );

endmodule

// File: tb/tb_sec09_queues_stream_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; a negedge
// monitor pops the expected byte stream for each instance on every byte transfer.
module tb_sec09_queues_stream_serializer;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic [31:0] in_msg;
    logic        out_rdy;
    logic        rdy0, oval0, olast0;
    logic [7:0]  omsg0;
    logic        rdy1, oval1, olast1;
    logic [7:0]  omsg1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    int byte_cyc [$];

    sec09_queues_stream_serializer #(.p_msb_first(1'b0)) dut0 (
        .clk(clk), .reset(reset), .istream_val(in_val), .istream_rdy(rdy0),
        .istream_msg(in_msg), .ostream_val(oval0), .ostream_rdy(out_rdy),
        .ostream_msg(omsg0), .ostream_last(olast0)
    );

    sec09_queues_stream_serializer #(.p_msb_first(1'b1)) dut1 (
        .clk(clk), .reset(reset), .istream_val(in_val), .istream_rdy(rdy1),
        .istream_msg(in_msg), .ostream_val(oval1), .ostream_rdy(out_rdy),
        .ostream_msg(omsg1), .ostream_last(olast1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            q0.push_back({(i == 3), w[i*8 +: 8]});
            q1.push_back({(i == 3), w[(3-i)*8 +: 8]});
        end
    endtask

    // Offers w until accepted; returns stall count, cycle of first byte and the
    // byte dut0 presented on the accepting cycle.
    task automatic send_word(input logic [31:0] w, input bit flaky,
                             output int waits, output int acc, output logic [7:0] acc_byte);
        bit done;
        done = 1'b0;
        waits = 0;
        acc = 0;
        acc_byte = 8'h00;
        in_msg = w;
        while (!done) begin
            in_val = flaky ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (flaky) out_rdy = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_val && rdy0) begin
                push_word(w);
                acc = cyc + 1;
                acc_byte = omsg0;
                if (!flaky) $display("word %08h accepted, first byte at cycle %0d", w, acc);
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 500) begin
                    chk("accept_timeout", 32'(waits), 32'd500);
                    done = 1'b1;
                end
            end
            step();
        end
        in_val = 1'b0;
        in_msg = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            step();
            n++;
        end
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (reset && oval0 && out_rdy) begin
            byte_cyc.push_back(cyc);
            if (q0.size() == 0) chk("lsb_unexpected_byte", {23'd0, olast0, omsg0}, 32'h1ff);
            else begin
                e = q0.pop_front();
                chk("lsb_byte", {24'd0, omsg0}, {24'd0, e[7:0]});
                chk("lsb_last", {31'd0, olast0}, {31'd0, e[8]});
            end
        end
        if (reset && oval1 && out_rdy) begin
            if (q1.size() == 0) chk("msb_unexpected_byte", {23'd0, olast1, omsg1}, 32'h1ff);
            else begin
                e = q1.pop_front();
                chk("msb_byte", {24'd0, omsg1}, {24'd0, e[7:0]});
                chk("msb_last", {31'd0, olast1}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        int waits, acc, acc2;
        logic [7:0] ab;

        reset = 1'b0; in_val = 1'b0; in_msg = 32'h0; out_rdy = 1'b1;
        #3;
        chk("rst_istream_rdy", {31'd0, rdy0}, 32'd1);
        chk("rst_istream_rdy_msb", {31'd0, rdy1}, 32'd1);
        chk("rst_ostream_val", {31'd0, oval0}, 32'd0);
        chk("rst_ostream_last", {31'd0, olast0}, 32'd0);
        chk("rst_ostream_msg", {24'd0, omsg0}, 32'd0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // Single word, full-rate sink
        send_word(32'h11223344, 1'b0, waits, acc, ab);
        @(negedge clk);
        chk("single_latency_val", {31'd0, oval0}, 32'd1);
        chk("single_rdy_byte0", {31'd0, rdy0}, 32'd0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("single_rdy_byte3", {31'd0, rdy0}, 32'd1);
        chk("single_last_byte3", {31'd0, olast0}, 32'd1);
        step();
        drain();
        @(negedge clk);
        chk("idle_msg_zero", {24'd0, omsg0}, 32'd0);
        chk("idle_val_zero", {31'd0, oval0}, 32'd0);
        step();

        // Back-to-back words, no bubble
        byte_cyc.delete();
        send_word(32'hA0B0C0D0, 1'b0, waits, acc, ab);
        send_word(32'h01020304, 1'b0, waits, acc2, ab);
        chk("b2b_second_waits", 32'(waits), 32'd3);
        chk("b2b_accept_on_A0", {24'd0, ab}, 32'hA0);
        drain();
        chk("b2b_byte_count", 32'(byte_cyc.size()), 32'd8);
        if (byte_cyc.size() == 8) begin
            chk("b2b_first_latency", 32'(byte_cyc[0]), 32'(acc));
            chk("b2b_no_gap", 32'(byte_cyc[7] - byte_cyc[0]), 32'd7);
        end

        // Backpressure at cnt=1, with a competing word offered during the stall
        send_word(32'hDEADBEEF, 1'b0, waits, acc, ab);
        step();
        out_rdy = 1'b0;
        in_val = 1'b1;
        in_msg = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold_lsb", {24'd0, omsg0}, 32'hBE);
            chk("stall_hold_msb", {24'd0, omsg1}, 32'hAD);
            chk("stall_rdy", {31'd0, rdy0}, 32'd0);
            chk("stall_rdy_msb", {31'd0, rdy1}, 32'd0);
            step();
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        drain();

        // Async reset in the middle of a word
        send_word(32'hCAFEF00D, 1'b0, waits, acc, ab);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_val", {31'd0, oval0}, 32'd0);
        chk("async_rst_msg", {24'd0, omsg0}, 32'd0);
        chk("async_rst_rdy", {31'd0, rdy0}, 32'd1);
        chk("async_rst_last", {31'd0, olast0}, 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_silent", {31'd0, oval0}, 32'd0);
            step();
        end
        send_word(32'h00000055, 1'b0, waits, acc, ab);
        drain();

        // Random stalls on both sides
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                in_val = 1'b0;
                in_msg = $urandom;
                out_rdy = ($urandom_range(0, 2) != 0);
                step();
            end
            send_word($urandom, 1'b1, waits, acc, ab);
        end
        out_rdy = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
